// File: rtl/user_multi_timer_pkg.sv
// Shared types for the user-domain multi-channel timer: channel FSM states and run modes.
// Imported by the channel sub-module and the timer top.
package user_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_e;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } timer_mode_e;

endpackage

// File: rtl/user_multi_timer_if.sv
// Configuration/status bundle between the register front-end (master) and the timer (slave).
// Pure wiring; no latency, no backpressure.
interface user_multi_timer_if #(
    parameter int NumChannels = 4,
    parameter int CntWidth    = 16,
    parameter int PrescWidth  = 8
);
    logic [PrescWidth-1:0]           prescale_i;
    logic [NumChannels-1:0]          enable_i;
    logic [NumChannels-1:0]          mode_i;
    logic [NumChannels-1:0]          clear_i;
    logic [NumChannels*CntWidth-1:0] end_val_i;
    logic [NumChannels-1:0]          irq_ack_i;
    logic [NumChannels*CntWidth-1:0] count_o;
    logic [NumChannels-1:0]          done_o;
    logic [NumChannels-1:0]          irq_o;
    logic [NumChannels-1:0]          busy_o;

    modport master (
        output prescale_i, enable_i, mode_i, clear_i, end_val_i, irq_ack_i,
        input  count_o, done_o, irq_o, busy_o
    );

    modport slave (
        input  prescale_i, enable_i, mode_i, clear_i, end_val_i, irq_ack_i,
        output count_o, done_o, irq_o, busy_o
    );
endinterface

// File: rtl/user_multi_timer_channel.sv
// One timer channel: IDLE/RUN/EXPIRED FSM, up-counter to end_val-1 and a sticky irq flop.
// done is combinational in the terminal-tick cycle; irq follows one cycle later; no backpressure.
module user_timer_channel
    import user_timer_pkg::*;
#(
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tick,
    input  logic                enable,
    input  timer_mode_e         mode,
    input  logic                clear,
    input  logic [CntWidth-1:0] end_val,
    input  logic                irq_ack,
    output logic [CntWidth-1:0] count,
    output logic                done,
    output logic                irq,
    output logic                busy
);
    timer_state_e        state_q, state_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic [CntWidth-1:0] term;
    logic                irq_q;

    // end_val of 0 wraps to all-ones, giving the full 2^CntWidth period
    assign term = end_val - CntWidth'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done    = 1'b0;
        if (!enable || clear) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = RUN;
                    count_d = '0;
                end
                RUN: begin
                    if (tick) begin
                        if (count_q == term) begin
                            done = !rst_i;
                            if (mode == MODE_ONESHOT) state_d = EXPIRED;
                            else                      count_d = '0;
                        end else begin
                            count_d = count_q + CntWidth'(1);
                        end
                    end
                end
                EXPIRED: begin
                    state_d = EXPIRED;
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (done)         irq_q <= 1'b1;
            else if (irq_ack) irq_q <= 1'b0;
        end
    end

    assign count = count_q;
    assign irq   = irq_q;
    assign busy  = (state_q == RUN);
endmodule

// File: rtl/user_multi_timer.sv
// Multi-channel timer: shared prescaler feeding NumChannels independent channels.
// done_o same cycle as the terminal tick, irq_o one cycle later; no backpressure.
module user_multi_timer
    import user_timer_pkg::*;
#(
    parameter int NumChannels = 4,
    parameter int CntWidth    = 16,
    parameter int PrescWidth  = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    user_multi_timer_if.slave bus
);
    logic [PrescWidth-1:0]  presc_cnt;
    logic [NumChannels-1:0] busy;
    logic                   any_busy;
    logic                   tick;

    assign any_busy = |busy;
    assign tick     = (presc_cnt == bus.prescale_i);

    // Past-prescale values simply run on through all-ones and wrap back to 0
    always_ff @(posedge clk_i) begin
        if (rst_i)                 presc_cnt <= '0;
        else if (!any_busy || tick) presc_cnt <= '0;
        else                       presc_cnt <= presc_cnt + PrescWidth'(1);
    end

    for (genvar k = 0; k < NumChannels; k++) begin : g_ch
        user_timer_channel #(
            .CntWidth (CntWidth)
        ) u_ch (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .tick    (tick),
            .enable  (bus.enable_i[k]),
            .mode    (timer_mode_e'(bus.mode_i[k])),
            .clear   (bus.clear_i[k]),
            .end_val (bus.end_val_i[k*CntWidth +: CntWidth]),
            .irq_ack (bus.irq_ack_i[k]),
            .count   (bus.count_o[k*CntWidth +: CntWidth]),
            .done    (bus.done_o[k]),
            .irq     (bus.irq_o[k]),
            .busy    (busy[k])
        );
    end

    assign bus.busy_o = busy;
endmodule

// File: tb/tb_user_multi_timer.sv
// Self-checking bench for user_multi_timer: directed scenarios plus randomized traffic
// compared against a tick-counting reference model.
module tb_user_multi_timer;
    localparam int NC = 4;
    localparam int CW = 4;
    localparam int PW = 8;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    user_multi_timer_if #(.NumChannels(NC), .CntWidth(CW), .PrescWidth(PW)) bus ();

    user_multi_timer #(.NumChannels(NC), .CntWidth(CW), .PrescWidth(PW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: each channel remembers how many ticks it has seen since starting.
    bit m_run   [NC];
    bit m_exp   [NC];
    bit m_irq   [NC];
    int m_ticks [NC];
    int m_brun;
    bit m_tk;
    logic [NC*CW-1:0] e_cnt;
    logic [NC-1:0]    e_done, e_irq, e_busy;

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_run[k] = 0; m_exp[k] = 0; m_irq[k] = 0; m_ticks[k] = 0;
        end
        m_brun = 0;
    endtask

    task automatic model_eval();
        int p;
        int per;
        p = int'(bus.prescale_i);
        m_tk = ((m_brun % (p + 1)) == p);
        for (int k = 0; k < NC; k++) begin
            per = (bus.end_val_i[k*CW +: CW] == '0) ? (1 << CW) : int'(bus.end_val_i[k*CW +: CW]);
            e_cnt[k*CW +: CW] = CW'(m_ticks[k] % per);
            e_busy[k] = m_run[k];
            e_irq[k]  = m_irq[k];
            e_done[k] = m_run[k] && m_tk && ((m_ticks[k] % per) == per - 1)
                        && bus.enable_i[k] && !bus.clear_i[k];
        end
    endtask

    task automatic model_update();
        bit any = 0;
        for (int k = 0; k < NC; k++) any |= m_run[k];
        for (int k = 0; k < NC; k++) begin
            if (e_done[k])              m_irq[k] = 1;
            else if (bus.irq_ack_i[k]) m_irq[k] = 0;
            if (!bus.enable_i[k] || bus.clear_i[k]) begin
                m_run[k] = 0; m_exp[k] = 0; m_ticks[k] = 0;
            end else if (!m_run[k] && !m_exp[k]) begin
                m_run[k] = 1; m_ticks[k] = 0;
            end else if (m_run[k] && m_tk) begin
                if (e_done[k] && bus.mode_i[k]) begin
                    m_run[k] = 0; m_exp[k] = 1;
                end else begin
                    m_ticks[k]++;
                end
            end
        end
        m_brun = any ? m_brun + 1 : 0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i          = 1'b1;
        bus.prescale_i = '0;
        bus.enable_i   = '0;
        bus.mode_i     = '0;
        bus.clear_i    = '0;
        bus.end_val_i  = '0;
        bus.irq_ack_i  = '0;
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst_i          = 1'b1;
        bus.prescale_i = '0;
        bus.enable_i   = '1;
        bus.mode_i     = '0;
        bus.clear_i    = '0;
        bus.irq_ack_i  = '0;
        for (int k = 0; k < NC; k++) bus.end_val_i[k*CW +: CW] = CW'(5);
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            total++; if (bus.count_o !== '0) begin bad++; $display("FAIL reset_count c=%0d got=%h exp=0", c, bus.count_o); end
            total++; if (bus.done_o  !== '0) begin bad++; $display("FAIL reset_done c=%0d got=%b exp=0", c, bus.done_o); end
            total++; if (bus.irq_o   !== '0) begin bad++; $display("FAIL reset_irq c=%0d got=%b exp=0", c, bus.irq_o); end
            total++; if (bus.busy_o  !== '0) begin bad++; $display("FAIL reset_busy c=%0d got=%b exp=0", c, bus.busy_o); end
            next_cycle();
        end
    endtask

    task automatic test_periodic();
        do_reset();
        bus.end_val_i[0 +: CW] = CW'(5);
        bus.enable_i[0] = 1'b1;
        @(negedge clk_i);
        total++; if (bus.busy_o[0] !== 1'b0) begin bad++; $display("FAIL per_idle_busy got=%b exp=0", bus.busy_o[0]); end
        next_cycle();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            total++; if (bus.count_o[0 +: CW] !== CW'(i % 5)) begin bad++; $display("FAIL per_count i=%0d got=%0d exp=%0d", i, bus.count_o[0 +: CW], i % 5); end
            total++; if (bus.done_o[0] !== ((i % 5) == 4)) begin bad++; $display("FAIL per_done i=%0d got=%b exp=%b", i, bus.done_o[0], (i % 5) == 4); end
            total++; if (bus.irq_o[0] !== (i >= 5)) begin bad++; $display("FAIL per_irq i=%0d got=%b exp=%b", i, bus.irq_o[0], i >= 5); end
            total++; if (bus.busy_o[0] !== 1'b1) begin bad++; $display("FAIL per_busy i=%0d got=%b exp=1", i, bus.busy_o[0]); end
            next_cycle();
        end
        bus.enable_i[0] = 1'b0;
        next_cycle();
        @(negedge clk_i);
        total++; if (bus.count_o[0 +: CW] !== '0) begin bad++; $display("FAIL per_disable_count got=%0d exp=0", bus.count_o[0 +: CW]); end
    endtask

    task automatic test_oneshot();
        int ec;
        do_reset();
        bus.prescale_i = PW'(3);
        bus.end_val_i[0 +: CW] = CW'(3);
        bus.mode_i[0]   = 1'b1;
        bus.enable_i[0] = 1'b1;
        next_cycle();
        for (int i = 0; i < 20; i++) begin
            ec = (i / 4 > 2) ? 2 : i / 4;
            @(negedge clk_i);
            total++; if (bus.count_o[0 +: CW] !== CW'(ec)) begin bad++; $display("FAIL os_count i=%0d got=%0d exp=%0d", i, bus.count_o[0 +: CW], ec); end
            total++; if (bus.done_o[0] !== (i == 11)) begin bad++; $display("FAIL os_done i=%0d got=%b exp=%b", i, bus.done_o[0], i == 11); end
            total++; if (bus.busy_o[0] !== (i <= 11)) begin bad++; $display("FAIL os_busy i=%0d got=%b exp=%b", i, bus.busy_o[0], i <= 11); end
            next_cycle();
        end
        bus.enable_i[0] = 1'b0;
        next_cycle();
        bus.enable_i[0] = 1'b1;
        @(negedge clk_i);
        total++; if (bus.count_o[0 +: CW] !== '0) begin bad++; $display("FAIL os_restart_count got=%0d exp=0", bus.count_o[0 +: CW]); end
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            total++; if (bus.count_o[0 +: CW] !== CW'(i / 4)) begin bad++; $display("FAIL os_rerun_count i=%0d got=%0d exp=%0d", i, bus.count_o[0 +: CW], i / 4); end
            total++; if (bus.busy_o[0] !== 1'b1) begin bad++; $display("FAIL os_rerun_busy i=%0d got=%b exp=1", i, bus.busy_o[0]); end
            next_cycle();
        end
    endtask

    task automatic test_boundaries();
        do_reset();
        bus.end_val_i[0 +: CW] = CW'(1);
        bus.enable_i[0] = 1'b1;
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            total++; if (bus.done_o[0] !== 1'b1) begin bad++; $display("FAIL ev1_done i=%0d got=%b exp=1", i, bus.done_o[0]); end
            total++; if (bus.count_o[0 +: CW] !== '0) begin bad++; $display("FAIL ev1_count i=%0d got=%0d exp=0", i, bus.count_o[0 +: CW]); end
            next_cycle();
        end
        do_reset();
        bus.enable_i[0] = 1'b1;
        next_cycle();
        for (int i = 0; i < 34; i++) begin
            @(negedge clk_i);
            total++; if (bus.count_o[0 +: CW] !== CW'(i % 16)) begin bad++; $display("FAIL ev0_count i=%0d got=%0d exp=%0d", i, bus.count_o[0 +: CW], i % 16); end
            total++; if (bus.done_o[0] !== ((i % 16) == 15)) begin bad++; $display("FAIL ev0_done i=%0d got=%b exp=%b", i, bus.done_o[0], (i % 16) == 15); end
            next_cycle();
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.end_val_i[0 +: CW] = CW'(3);
        bus.enable_i[0] = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        bus.clear_i[0] = 1'b1;
        @(negedge clk_i);
        total++; if (bus.done_o[0] !== 1'b0) begin bad++; $display("FAIL clr_done got=%b exp=0", bus.done_o[0]); end
        next_cycle();
        bus.clear_i[0] = 1'b0;
        @(negedge clk_i);
        total++; if (bus.count_o[0 +: CW] !== '0) begin bad++; $display("FAIL clr_count got=%0d exp=0", bus.count_o[0 +: CW]); end
        total++; if (bus.busy_o[0] !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b exp=0", bus.busy_o[0]); end
        total++; if (bus.irq_o[0] !== 1'b0) begin bad++; $display("FAIL clr_irq got=%b exp=0", bus.irq_o[0]); end
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            bus.irq_ack_i[0] = (i == 5 || i == 6);
            @(negedge clk_i);
            total++; if (bus.done_o[0] !== ((i % 3) == 2)) begin bad++; $display("FAIL ack_done i=%0d got=%b exp=%b", i, bus.done_o[0], (i % 3) == 2); end
            total++; if (bus.irq_o[0] !== (i >= 3 && i <= 6)) begin bad++; $display("FAIL ack_irq i=%0d got=%b exp=%b", i, bus.irq_o[0], i >= 3 && i <= 6); end
            next_cycle();
        end
        bus.irq_ack_i = '0;
    endtask

    task automatic test_multi();
        int ch1_dones = 0;
        do_reset();
        bus.prescale_i = PW'(1);
        bus.end_val_i[0*CW +: CW] = CW'(3);
        bus.end_val_i[1*CW +: CW] = CW'(7);
        bus.end_val_i[2*CW +: CW] = CW'(5);
        bus.mode_i   = 4'b0010;
        bus.enable_i = 4'b0011;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            model_eval();
            total++; if (bus.count_o !== e_cnt) begin bad++; $display("FAIL multi_count c=%0d got=%h exp=%h", c, bus.count_o, e_cnt); end
            total++; if (bus.done_o !== e_done) begin bad++; $display("FAIL multi_done c=%0d got=%b exp=%b", c, bus.done_o, e_done); end
            total++; if (bus.irq_o !== e_irq) begin bad++; $display("FAIL multi_irq c=%0d got=%b exp=%b", c, bus.irq_o, e_irq); end
            total++; if (bus.busy_o !== e_busy) begin bad++; $display("FAIL multi_busy c=%0d got=%b exp=%b", c, bus.busy_o, e_busy); end
            total++; if (bus.count_o[2*CW +: CW] !== '0) begin bad++; $display("FAIL multi_ch2_count c=%0d got=%0d exp=0", c, bus.count_o[2*CW +: CW]); end
            if (bus.done_o[1]) ch1_dones++;
            model_update();
            next_cycle();
        end
        total++; if (ch1_dones != 1) begin bad++; $display("FAIL multi_ch1_done_count got=%0d exp=1", ch1_dones); end
        next_cycle();
        next_cycle();
        rst_i = 1'b1;
        @(negedge clk_i);
        total++; if (bus.done_o !== '0) begin bad++; $display("FAIL midrst_done_same got=%b exp=0", bus.done_o); end
        next_cycle();
        @(negedge clk_i);
        total++; if (bus.count_o !== '0) begin bad++; $display("FAIL midrst_count got=%h exp=0", bus.count_o); end
        total++; if (bus.done_o !== '0) begin bad++; $display("FAIL midrst_done got=%b exp=0", bus.done_o); end
        total++; if (bus.irq_o !== '0) begin bad++; $display("FAIL midrst_irq got=%b exp=0", bus.irq_o); end
        total++; if (bus.busy_o !== '0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy_o); end
        next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            bus.prescale_i = PW'($urandom_range(0, 3));
            for (int k = 0; k < NC; k++) bus.end_val_i[k*CW +: CW] = CW'($urandom_range(0, 9));
            bus.mode_i   = NC'($urandom);
            bus.enable_i = NC'($urandom);
            for (int c = 0; c < 250; c++) begin
                for (int k = 0; k < NC; k++) begin
                    if ($urandom_range(0, 15) == 0) bus.enable_i[k] = ~bus.enable_i[k];
                    bus.clear_i[k]   = ($urandom_range(0, 19) == 0);
                    bus.irq_ack_i[k] = ($urandom_range(0, 3) == 0);
                end
                @(negedge clk_i);
                model_eval();
                total++; if (bus.count_o !== e_cnt) begin bad++; $display("FAIL rnd_count s=%0d c=%0d got=%h exp=%h", seg, c, bus.count_o, e_cnt); end
                total++; if (bus.done_o !== e_done) begin bad++; $display("FAIL rnd_done s=%0d c=%0d got=%b exp=%b", seg, c, bus.done_o, e_done); end
                total++; if (bus.irq_o !== e_irq) begin bad++; $display("FAIL rnd_irq s=%0d c=%0d got=%b exp=%b", seg, c, bus.irq_o, e_irq); end
                total++; if (bus.busy_o !== e_busy) begin bad++; $display("FAIL rnd_busy s=%0d c=%0d got=%b exp=%b", seg, c, bus.busy_o, e_busy); end
                model_update();
                next_cycle();
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        test_reset();
        test_periodic();
        test_oneshot();
        test_boundaries();
        test_simultaneous();
        test_multi();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
